// File: rtl/gouram_trace_pkg.sv
// Shared types for the Gouram trackers.
// Provides the time type, the trace record carried between stage trackers,
// the interval record kept by the signal tracker, and the not-found sentinel.
package gouram_trace_pkg;

   localparam int unsigned TIME_W = 32;

   typedef logic signed [TIME_W-1:0] time_t;

   localparam time_t NOT_FOUND = -32'sd1;

   // Trace record passed between stage trackers
   typedef struct packed {
      time_t ex_data;
      time_t wb_data;
      time_t mem_access_req;
      time_t mem_access_res;
      logic  pass_through;
   } trace_format;

   // One high interval of a tracked signal
   typedef struct packed {
      time_t t_start;
      time_t t_end;
   } interval_t;

endpackage

// File: rtl/interval_store.sv
// Circular store of high-interval records with combinational search.
// Ports: clk/rst; counter_i timestamp; rise_i/fall_i sample events;
// prune_i/prune_end_i/keep_equal_i prune request; ref_i/ref_incl_i time query
// reference; lo_i/hi_i range query; time_c_o {start,end} and single_c_o
// are combinational answers computed on the current (pre-update) history.
module interval_store
   import gouram_trace_pkg::*;
#(
   parameter int unsigned BUFFER_SIZE = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  time_t       counter_i,
   input  logic        rise_i,
   input  logic        fall_i,
   input  logic        prune_i,
   input  time_t       prune_end_i,
   input  logic        keep_equal_i,
   input  time_t       ref_i,
   input  logic        ref_incl_i,
   input  time_t       lo_i,
   input  time_t       hi_i,
   output time_t [1:0] time_c_o,
   output time_t       single_c_o
);

   localparam int unsigned IW = $clog2(BUFFER_SIZE);
   localparam int unsigned CW = IW + 1;

   interval_t     rec_q [BUFFER_SIZE];
   logic [IW-1:0] head_q, head_d, tail;
   logic [CW-1:0] cnt_q, cnt_d, prune_n;
   logic          open_q, open_d;

   // Slot after the newest record; equals head when the store is full
   assign tail = head_q + cnt_q[IW-1:0];

   // Walk records oldest-first: time hit, range hit, and prunable prefix length.
   // Ends grow monotonically, so the deletable records always form a prefix.
   always_comb begin : search
      logic [IW-1:0] idx;
      time_t         e;
      logic          is_open, hit_t, hit_s, pfx;
      idx        = '0;
      e          = '0;
      is_open    = 1'b0;
      hit_t      = 1'b0;
      hit_s      = 1'b0;
      pfx        = prune_i;
      prune_n    = '0;
      time_c_o   = {NOT_FOUND, NOT_FOUND};
      single_c_o = NOT_FOUND;
      for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
         if (CW'(i) < cnt_q) begin
            idx     = head_q + IW'(i);
            is_open = open_q && (CW'(i) == cnt_q - CW'(1));
            // Open record counts as covered up to the previous cycle
            e       = is_open ? counter_i - 32'sd1 : rec_q[idx].t_end;
            if (!hit_t && ((rec_q[idx].t_start > ref_i) ||
                           (ref_incl_i && rec_q[idx].t_start == ref_i))) begin
               hit_t    = 1'b1;
               time_c_o = {rec_q[idx].t_start, (is_open ? NOT_FOUND : rec_q[idx].t_end)};
            end
            if (!hit_s && lo_i <= hi_i && rec_q[idx].t_start <= hi_i &&
                e >= lo_i && rec_q[idx].t_start <= e) begin
               hit_s      = 1'b1;
               single_c_o = (rec_q[idx].t_start > lo_i) ? rec_q[idx].t_start : lo_i;
            end
            if (pfx && !is_open && ((rec_q[idx].t_end < prune_end_i) ||
                (rec_q[idx].t_end == prune_end_i && !keep_equal_i)))
               prune_n = prune_n + CW'(1);
            else
               pfx = 1'b0;
         end
      end
   end

   // Prune first, then append; a full store drops its oldest record
   always_comb begin : update
      head_d = head_q + IW'(prune_n);
      cnt_d  = cnt_q - prune_n;
      open_d = open_q;
      if (fall_i) open_d = 1'b0;
      if (rise_i) begin
         open_d = 1'b1;
         if (cnt_d == CW'(BUFFER_SIZE)) head_d = head_d + IW'(1);
         else                           cnt_d  = cnt_d + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         cnt_q  <= '0;
         open_q <= 1'b0;
      end else begin
         head_q <= head_d;
         cnt_q  <= cnt_d;
         open_q <= open_d;
         if (rise_i) rec_q[tail] <= {counter_i, NOT_FOUND};
         if (fall_i && open_q) rec_q[tail - IW'(1)].t_end <= counter_i - 32'sd1;
      end
   end

endmodule

// File: rtl/signal_tracker.sv
// Records high intervals of a pipeline signal and answers time/range queries.
// Ports: clk/rst; counter timestamp; tracked_signal; value_in + recalculate_time
// -> time_out {start,end}; range_in {lo,hi} + recalculate_single_cycle
// -> single_cycle_out; previous_end_i/update_end/previous_end_memory prune;
// ready_flag/ex_ready_flag/data_mem_req_flag static mode straps.
module signal_tracker
   import gouram_trace_pkg::*;
#(
   parameter int unsigned SIGNAL_WIDTH = 1,
   parameter int unsigned BUFFER_SIZE  = 128
) (
   input  logic                    clk,
   input  logic                    rst,
   input  time_t                   counter,
   input  logic [SIGNAL_WIDTH-1:0] tracked_signal,
   input  time_t                   value_in,
   input  logic                    recalculate_time,
   output time_t [1:0]             time_out,
   input  time_t [0:1]             range_in,
   input  logic                    recalculate_single_cycle,
   output time_t                   single_cycle_out,
   input  time_t                   previous_end_i,
   input  logic                    update_end,
   input  logic                    previous_end_memory,
   input  logic                    ready_flag,
   input  logic                    ex_ready_flag,
   input  logic                    data_mem_req_flag
);

   logic        sig_q, sig_d;
   time_t [1:0] time_q, time_d, time_c;
   time_t       single_q, single_d, single_c;

   interval_store #(.BUFFER_SIZE(BUFFER_SIZE)) u_store (
      .clk          (clk),
      .rst          (rst),
      .counter_i    (counter),
      .rise_i       (tracked_signal[0] && !sig_q),
      .fall_i       (!tracked_signal[0] && sig_q),
      .prune_i      (update_end),
      .prune_end_i  (previous_end_i),
      // An end shared with a memory phase stays for the overlapping stage
      .keep_equal_i (previous_end_memory && (ex_ready_flag || data_mem_req_flag)),
      .ref_i        (counter - value_in),
      .ref_incl_i   (ready_flag),
      .lo_i         (range_in[0]),
      .hi_i         (range_in[1]),
      .time_c_o     (time_c),
      .single_c_o   (single_c)
   );

   // Results update on a request and hold otherwise
   always_comb begin
      sig_d    = tracked_signal[0];
      time_d   = recalculate_time ? time_c : time_q;
      single_d = recalculate_single_cycle ? single_c : single_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q    <= 1'b0;
         time_q   <= {NOT_FOUND, NOT_FOUND};
         single_q <= NOT_FOUND;
      end else begin
         sig_q    <= sig_d;
         time_q   <= time_d;
         single_q <= single_d;
      end
   end

   assign time_out         = time_q;
   assign single_cycle_out = single_q;

endmodule

// File: rtl/trace_buffer.sv
// Show-ahead FIFO carrying trace records between stage trackers.
// Ports: clk/rst; ready_signal pushes trace_element_in; data_request pops;
// data_present = not empty; trace_element_out shows the head.
module trace_buffer #(
   parameter int unsigned TRACE_BUFFER_SIZE = 32,
   parameter type trace_format = gouram_trace_pkg::trace_format
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready_signal,
   input  trace_format trace_element_in,
   input  logic        data_request,
   output logic        data_present,
   output trace_format trace_element_out
);

   localparam int unsigned AW = $clog2(TRACE_BUFFER_SIZE);
   localparam int unsigned CW = AW + 1;

   trace_format   mem_q [TRACE_BUFFER_SIZE];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   // Full drops the push unless a pop frees a slot in the same cycle
   always_comb begin
      pop   = data_request && (cnt_q != '0);
      push  = ready_signal && ((cnt_q != CW'(TRACE_BUFFER_SIZE)) || pop);
      rd_d  = rd_q + AW'(pop);
      wr_d  = wr_q + AW'(push);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         if (push) mem_q[wr_q] <= trace_element_in;
      end
   end

   assign data_present      = (cnt_q != '0);
   assign trace_element_out = mem_q[rd_q];

endmodule

// File: rtl/trace_signal_tracking.sv
// Timing-recovery slice: one signal tracker and one trace FIFO on a shared clock.
// Ports: tracker ports (counter ... data_mem_req_flag) and FIFO ports
// (ready_signal, trace_element_in, data_request, data_present, trace_element_out).
module trace_signal_tracking
   import gouram_trace_pkg::*;
#(
   parameter int unsigned BUFFER_SIZE       = 128,
   parameter int unsigned TRACE_BUFFER_SIZE = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  time_t       counter,
   input  logic        tracked_signal,
   input  time_t       value_in,
   input  logic        recalculate_time,
   output time_t [1:0] time_out,
   input  time_t [0:1] range_in,
   input  logic        recalculate_single_cycle,
   output time_t       single_cycle_out,
   input  time_t       previous_end_i,
   input  logic        update_end,
   input  logic        previous_end_memory,
   input  logic        ready_flag,
   input  logic        ex_ready_flag,
   input  logic        data_mem_req_flag,
   input  logic        ready_signal,
   input  trace_format trace_element_in,
   input  logic        data_request,
   output logic        data_present,
   output trace_format trace_element_out
);

   signal_tracker #(.SIGNAL_WIDTH(1), .BUFFER_SIZE(BUFFER_SIZE)) u_tracker (
      .clk                      (clk),
      .rst                      (rst),
      .counter                  (counter),
      .tracked_signal           (tracked_signal),
      .value_in                 (value_in),
      .recalculate_time         (recalculate_time),
      .time_out                 (time_out),
      .range_in                 (range_in),
      .recalculate_single_cycle (recalculate_single_cycle),
      .single_cycle_out         (single_cycle_out),
      .previous_end_i           (previous_end_i),
      .update_end               (update_end),
      .previous_end_memory      (previous_end_memory),
      .ready_flag               (ready_flag),
      .ex_ready_flag            (ex_ready_flag),
      .data_mem_req_flag        (data_mem_req_flag)
   );

   trace_buffer #(.TRACE_BUFFER_SIZE(TRACE_BUFFER_SIZE)) u_buffer (
      .clk               (clk),
      .rst               (rst),
      .ready_signal      (ready_signal),
      .trace_element_in  (trace_element_in),
      .data_request      (data_request),
      .data_present      (data_present),
      .trace_element_out (trace_element_out)
   );

endmodule

// File: tb/tb_trace_signal_tracking.sv
// Bench for trace_signal_tracking: directed scenarios plus randomized traffic
// against a queue-based interval model and a reference FIFO queue.
module tb_trace_signal_tracking;
   import gouram_trace_pkg::*;

   localparam int unsigned BSZ = 128;
   localparam int unsigned FSZ = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   time_t       counter, value_in, previous_end_i, single_cycle_out;
   logic        tracked_signal, recalculate_time, recalculate_single_cycle;
   logic        update_end, previous_end_memory;
   logic        ready_flag, ex_ready_flag, data_mem_req_flag;
   time_t [1:0] time_out;
   time_t [0:1] range_in;
   logic        ready_signal, data_request, data_present;
   trace_format trace_element_in, trace_element_out;

   trace_signal_tracking #(.BUFFER_SIZE(BSZ), .TRACE_BUFFER_SIZE(FSZ)) dut (
      .clk(clk), .rst(rst), .counter(counter), .tracked_signal(tracked_signal),
      .value_in(value_in), .recalculate_time(recalculate_time), .time_out(time_out),
      .range_in(range_in), .recalculate_single_cycle(recalculate_single_cycle),
      .single_cycle_out(single_cycle_out), .previous_end_i(previous_end_i),
      .update_end(update_end), .previous_end_memory(previous_end_memory),
      .ready_flag(ready_flag), .ex_ready_flag(ex_ready_flag),
      .data_mem_req_flag(data_mem_req_flag), .ready_signal(ready_signal),
      .trace_element_in(trace_element_in), .data_request(data_request),
      .data_present(data_present), .trace_element_out(trace_element_out)
   );

   // Reference history: list of intervals, oldest first
   typedef struct { int s; int e; bit open; } rec_t;
   rec_t        mq[$];
   bit          m_prev;
   int          exp_ts, exp_te, exp_sc;
   int          n_cmp, n_fail;
   trace_format exp_f[$];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_elem(input string tag, input trace_format obs, input trace_format exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit covered(input int t);
      foreach (mq[i]) begin
         if (mq[i].s <= t && t <= (mq[i].open ? int'(counter) - 1 : mq[i].e)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_prev = 1'b0;
      exp_ts = -1; exp_te = -1; exp_sc = -1;
   endfunction

   // Answers use the history as it stood before this cycle's sample/prune
   function automatic void model_queries();
      int  r;
      bit  found;
      if (recalculate_time) begin
         r = counter - value_in;
         exp_ts = -1; exp_te = -1; found = 1'b0;
         foreach (mq[i]) begin
            if (!found && (mq[i].s > r || (ready_flag && mq[i].s == r))) begin
               found  = 1'b1;
               exp_ts = mq[i].s;
               exp_te = mq[i].open ? -1 : mq[i].e;
            end
         end
      end
      if (recalculate_single_cycle) begin
         exp_sc = -1;
         for (int t = range_in[1]; t >= range_in[0]; t--)
            if (covered(t)) exp_sc = t;
      end
   endfunction

   function automatic void model_update();
      rec_t r;
      bit   keep_eq;
      keep_eq = previous_end_memory && (ex_ready_flag || data_mem_req_flag);
      if (update_end) begin
         for (int i = int'(mq.size()) - 1; i >= 0; i--)
            if (!mq[i].open && (mq[i].e < previous_end_i ||
                (mq[i].e == previous_end_i && !keep_eq)))
               mq.delete(i);
      end
      if (tracked_signal && !m_prev) begin
         r.s = counter; r.e = -1; r.open = 1'b1;
         mq.push_back(r);
         if (mq.size() > BSZ) void'(mq.pop_front());
      end else if (!tracked_signal && m_prev && mq.size() > 0) begin
         r = mq[mq.size()-1];
         if (r.open) begin
            r.e = counter - 1; r.open = 1'b0;
            mq[mq.size()-1] = r;
         end
      end
      m_prev = tracked_signal;
   endfunction

   // One clock: update model, let the DUT sample, clear pulses, compare outputs
   task automatic cyc();
      if (rst) model_reset();
      else begin
         model_queries();
         model_update();
      end
      @(posedge clk);
      #1;
      counter = counter + 1;
      recalculate_time = 1'b0; recalculate_single_cycle = 1'b0; update_end = 1'b0;
      ready_signal = 1'b0; data_request = 1'b0;
      check("time_start", time_out[1], exp_ts);
      check("time_end", time_out[0], exp_te);
      check("single", single_cycle_out, exp_sc);
   endtask

   task automatic run_to(input int c);
      while (counter < c) cyc();
   endtask

   task automatic do_reset(input bit rf, input bit ef, input bit mf);
      ready_flag = rf; ex_ready_flag = ef; data_mem_req_flag = mf;
      tracked_signal = 1'b0;
      rst = 1'b1; counter = 0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic query_time(input int r);
      value_in = counter - r; recalculate_time = 1'b1; cyc();
   endtask

   task automatic query_range(input int lo, input int hi);
      range_in[0] = lo; range_in[1] = hi; recalculate_single_cycle = 1'b1; cyc();
   endtask

   task automatic prune(input int pe, input bit mem);
      previous_end_i = pe; previous_end_memory = mem; update_end = 1'b1; cyc();
   endtask

   task automatic pulse(input int s, input int e);
      run_to(s); tracked_signal = 1'b1; run_to(e + 1); tracked_signal = 1'b0;
   endtask

   function automatic trace_format rand_elem();
      trace_format t;
      t.ex_data = $urandom; t.wb_data = $urandom;
      t.mem_access_req = $urandom; t.mem_access_res = $urandom;
      t.pass_through = 1'($urandom_range(0, 1));
      return t;
   endfunction

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; counter = 0; tracked_signal = 1'b0; value_in = 0;
      recalculate_time = 1'b0; recalculate_single_cycle = 1'b0;
      range_in[0] = 0; range_in[1] = 0; previous_end_i = 0;
      update_end = 1'b0; previous_end_memory = 1'b0;
      ready_flag = 1'b0; ex_ready_flag = 1'b0; data_mem_req_flag = 1'b0;
      ready_signal = 1'b0; data_request = 1'b0; trace_element_in = '0;

      // Reset state
      do_reset(1'b0, 1'b0, 1'b0);
      check("rst_time_start", time_out[1], -1);
      check("rst_time_end", time_out[0], -1);
      check("rst_single", single_cycle_out, -1);
      check("rst_present", data_present, 0);

      // Closed interval 10..12 found from R = 5
      pulse(10, 12);
      run_to(20);
      query_time(5);
      check("closed_start", time_out[1], 10);
      check("closed_end", time_out[0], 12);

      // Open interval from 30; nothing after R = 30
      run_to(30); tracked_signal = 1'b1;
      run_to(35);
      query_time(25);
      check("open_start", time_out[1], 30);
      check("open_end", time_out[0], -1);
      query_time(30);
      check("none_start", time_out[1], -1);
      check("none_end", time_out[0], -1);
      run_to(38); tracked_signal = 1'b0;

      // Range queries over pulses at 40 and 45..46
      pulse(40, 40);
      pulse(45, 46);
      run_to(55);
      query_range(42, 50);
      check("range_hit", single_cycle_out, 45);
      query_range(47, 50);
      check("range_miss", single_cycle_out, -1);

      // Inclusive reference with a one-cycle pulse
      do_reset(1'b1, 1'b0, 1'b0);
      pulse(10, 10);
      run_to(15);
      query_time(10);
      check("incl_start", time_out[1], 10);
      check("incl_end", time_out[0], 10);

      // Prune below 15 removes the 10-ending record only
      do_reset(1'b0, 1'b0, 1'b0);
      pulse(5, 10);
      pulse(15, 20);
      run_to(25);
      prune(15, 1'b0);
      query_time(0);
      check("prune_start", time_out[1], 15);
      check("prune_end", time_out[0], 20);

      // Reset during a query discards it
      rst = 1'b1; counter = 0; value_in = 0; recalculate_time = 1'b1;
      ready_flag = 1'b0; ex_ready_flag = 1'b0; data_mem_req_flag = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      check("rstq_start", time_out[1], -1);
      check("rstq_end", time_out[0], -1);

      // Memory strap keeps an equal-end record; plain prune deletes it
      pulse(5, 10);
      pulse(15, 20);
      run_to(25);
      prune(20, 1'b1);
      query_time(0);
      check("keep_start", time_out[1], 15);
      check("keep_end", time_out[0], 20);
      prune(20, 1'b0);
      query_time(0);
      check("drop_start", time_out[1], -1);
      check("drop_end", time_out[0], -1);

      // Random traffic, no pruning: overflows the record store
      do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 1200; k++) begin
         if ($urandom_range(0, 2) == 0) tracked_signal = ~tracked_signal;
         if ($urandom_range(0, 3) == 0) begin
            value_in = $urandom_range(0, int'(counter));
            recalculate_time = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            range_in[0] = counter - 32'($urandom_range(0, 80));
            range_in[1] = range_in[0] + 32'($urandom_range(0, 40)) - 32'sd5;
            recalculate_single_cycle = 1'b1;
         end
         cyc();
      end

      // Random traffic with occasional pruning under random straps
      do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 1000; k++) begin
         if ($urandom_range(0, 2) == 0) tracked_signal = ~tracked_signal;
         if ($urandom_range(0, 3) == 0) begin
            value_in = $urandom_range(0, 150);
            recalculate_time = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            range_in[0] = counter - 32'($urandom_range(0, 80));
            range_in[1] = range_in[0] + 32'($urandom_range(0, 40));
            recalculate_single_cycle = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) begin
            previous_end_i = counter - 32'($urandom_range(0, 100));
            previous_end_memory = 1'($urandom_range(0, 1));
            update_end = 1'b1;
         end
         cyc();
      end
      tracked_signal = 1'b0;

      // FIFO: 33 pushes keep 32, drain in order
      do_reset(1'b0, 1'b0, 1'b0);
      check("fifo_empty", data_present, 0);
      for (int i = 0; i < FSZ + 1; i++) begin
         trace_element_in = rand_elem();
         if (i < int'(FSZ)) exp_f.push_back(trace_element_in);
         ready_signal = 1'b1;
         cyc();
      end
      for (int i = 0; i < FSZ; i++) begin
         check("fifo_present", data_present, 1);
         check_elem("fifo_head", trace_element_out, exp_f[i]);
         data_request = 1'b1;
         cyc();
      end
      check("fifo_drained", data_present, 0);

      // Pop on empty is ignored
      data_request = 1'b1; cyc();
      exp_f.delete();
      exp_f.push_back(rand_elem());
      exp_f.push_back(rand_elem());
      trace_element_in = exp_f[0]; ready_signal = 1'b1; cyc();
      check("one_present", data_present, 1);
      check_elem("one_head", trace_element_out, exp_f[0]);

      // Simultaneous push and pop on one entry
      trace_element_in = exp_f[1]; ready_signal = 1'b1; data_request = 1'b1; cyc();
      check("pp_present", data_present, 1);
      check_elem("pp_head", trace_element_out, exp_f[1]);
      data_request = 1'b1; cyc();
      check("pp_empty", data_present, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
